seg_rx_decoder: RTL

//  Receive side of the seven-segment display interface: samples a time-multiplexed, active-low

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_pat_decode.sv | 22 ++
 rtl/seg_rx_decoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Seven-segment bus definitions shared by the display driver and the loopback receiver.
// Patterns are a..g active-high with a in bit 6; dp is carried separately.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  typedef logic [7:0] seg_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } rx_state_e;

  localparam logic [6:0] HEX_PAT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg_pat_decode.sv
// Maps an active-high a..g pattern back to its hex nibble; unknown patterns flag err
// and decode as 0.
module seg_pat_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pat == HEX_PAT[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_rx_decoder.sv
// Samples a multiplexed active-low segment bus, debounces each digit and presents the
// decoded multi-digit frame on a valid/ready port.
//   state      | meaning
//   ST_COLLECT | sampling digits until every digit is accepted
//   ST_HOLD    | frame presented on out_valid, samples ignored until handshake
module seg_rx_decoder
  import seg_pkg::*;
#(
  parameter int NDIG       = 2,
  parameter int STABLE_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [7:0]        seg_n,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [4*NDIG-1:0] out_value,
  output logic [NDIG-1:0]   out_dp,
  output logic [NDIG-1:0]   out_err,
  output logic              sel_err
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  rx_state_e       state_q, state_d;
  seg_t            last_q [NDIG];
  logic [CW-1:0]   cnt_q  [NDIG];
  logic [3:0]      nib_q  [NDIG];
  logic [NDIG-1:0] accept_q;
  logic [NDIG-1:0] dp_q;
  logic [NDIG-1:0] err_q;

  logic [3:0] dec_nib;
  logic       dec_err;
  logic       sel_onehot;
  logic       take;
  logic       handshake;
  logic       load_out;

  // Only one digit is lit per sample, so a single decoder serves all digits.
  seg_pat_decode u_dec (
    .pat    (seg_n[SEG_A:SEG_G] ^ 7'h7F),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  assign sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
  assign take       = (state_q == ST_COLLECT) && sample_en && sel_onehot;
  assign handshake  = (state_q == ST_HOLD) && out_ready;
  assign load_out   = (state_q == ST_COLLECT) && (&accept_q);
  assign out_valid  = (state_q == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (&accept_q) state_d = ST_HOLD;
      ST_HOLD:    if (out_ready) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accept_q  <= '0;
      dp_q      <= '0;
      err_q     <= '0;
      out_value <= '0;
      out_dp    <= '0;
      out_err   <= '0;
      sel_err   <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        last_q[i] <= '0;
        cnt_q[i]  <= '0;
        nib_q[i]  <= '0;
      end
    end else begin
      sel_err <= (state_q == ST_COLLECT) && sample_en && !sel_onehot;
      if (handshake) begin
        accept_q <= '0;
        for (int i = 0; i < NDIG; i++) begin
          last_q[i] <= '0;
          cnt_q[i]  <= '0;
        end
      end else if (take) begin
        for (int i = 0; i < NDIG; i++) begin
          if (dig_sel[i]) begin
            if (seg_n == last_q[i]) begin
              if (cnt_q[i] != CW'(STABLE_CNT)) cnt_q[i] <= cnt_q[i] + CW'(1);
              if (cnt_q[i] == CW'(STABLE_CNT - 1)) begin
                accept_q[i] <= 1'b1;
                nib_q[i]    <= dec_nib;
                dp_q[i]     <= ~seg_n[SEG_DP];
                err_q[i]    <= dec_err;
              end
            end else begin
              last_q[i]   <= seg_n;
              cnt_q[i]    <= CW'(1);
              accept_q[i] <= 1'b0;
            end
          end
        end
      end
      // Output registers only change when a complete frame moves into HOLD.
      if (load_out) begin
        out_dp  <= dp_q;
        out_err <= err_q;
        for (int i = 0; i < NDIG; i++) out_value[4*i +: 4] <= nib_q[i];
      end
    end
  end

endmodule
